// File: rtl/ln_pkg.sv
// ln_pkg: definitions shared by ln_stat_collector and layer_norm.
//   STAT_W / MEAN_FRAC / VAR_FRAC : format of the packed per-token statistics
//   LN_NUM_DEF / LOG2N            : default token length and its log2
//   ln_stat_t                     : LUT word {var_q, mean_q}; layer_norm unpacks with the same type
//   ln_state_e                    : collector FSM states
package ln_pkg;
  localparam int STAT_W     = 16;
  localparam int MEAN_FRAC  = 8;
  localparam int VAR_FRAC   = 0;
  localparam int LN_NUM_DEF = 256;
  localparam int LOG2N      = $clog2(LN_NUM_DEF);

  typedef struct packed {
    logic [STAT_W-1:0] var_q;
    logic [STAT_W-1:0] mean_q;
  } ln_stat_t;

  typedef enum logic [1:0] {ACC, CALC, WRITE} ln_state_e;
endpackage

// File: rtl/ln_beat_reduce.sv
// ln_beat_reduce: combinational sum and sum-of-squares of one input beat.
//   data_i  : DATA_DEPTH signed elements, element k at [k*INT_WIDTH +: INT_WIDTH]
//   sum_o   : signed sum,  INT_WIDTH+log2(DATA_DEPTH) bits
//   sumsq_o : unsigned sum of squares, 2*INT_WIDTH+log2(DATA_DEPTH) bits
module ln_beat_reduce #(
  parameter int DATA_DEPTH = 8,
  parameter int INT_WIDTH  = 8
) (
  input  logic [DATA_DEPTH*INT_WIDTH-1:0]                  data_i,
  output logic signed [INT_WIDTH+$clog2(DATA_DEPTH)-1:0]   sum_o,
  output logic [2*INT_WIDTH+$clog2(DATA_DEPTH)-1:0]        sumsq_o
);
  localparam int RSW = INT_WIDTH + $clog2(DATA_DEPTH);
  localparam int RQW = 2*INT_WIDTH + $clog2(DATA_DEPTH);
  localparam int PW  = 2*INT_WIDTH;

  logic signed [PW-1:0] elem_x;
  logic signed [PW-1:0] prod;

  // Written as a loop; synthesis balances it into an adder tree.
  always_comb begin
    sum_o   = '0;
    sumsq_o = '0;
    elem_x  = '0;
    prod    = '0;
    for (int k = 0; k < DATA_DEPTH; k++) begin
      elem_x  = PW'($signed(data_i[k*INT_WIDTH +: INT_WIDTH]));
      prod    = elem_x * elem_x;  // square of a signed element, never negative
      sum_o   = sum_o + RSW'($signed(data_i[k*INT_WIDTH +: INT_WIDTH]));
      sumsq_o = sumsq_o + RQW'($unsigned(prod));
    end
  end
endmodule

// File: rtl/ln_stat_collector.sv
// ln_stat_collector: accumulates per-token sum / sum-of-squares over LN_NUM
// elements and writes {var, mean} for each token into layer_norm's stat LUT.
//   clk, rst_n  : clock, async active-low reset
//   seq_clr     : clears token index and discards any partial token
//   valid_in / in_ready / input_data : beat input (DATA_DEPTH elements)
//   lut_wen / lut_addr / lut_wdata   : one write per completed token
//   tok_done    : mirrors lut_wen
module ln_stat_collector
  import ln_pkg::*;
#(
  parameter int DATA_DEPTH = 8,
  parameter int INT_WIDTH  = 8,
  parameter int LN_NUM     = LN_NUM_DEF,
  parameter int LUT_DEPTH  = 256
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            seq_clr,
  input  logic                            valid_in,
  output logic                            in_ready,
  input  logic [DATA_DEPTH*INT_WIDTH-1:0] input_data,
  output logic                            lut_wen,
  output logic [$clog2(LUT_DEPTH)-1:0]    lut_addr,
  output logic [2*STAT_W-1:0]             lut_wdata,
  output logic                            tok_done
);
  localparam int BEATS = LN_NUM / DATA_DEPTH;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW    = $clog2(LUT_DEPTH);
  localparam int L2N   = $clog2(LN_NUM);
  localparam int LD    = $clog2(DATA_DEPTH);
  localparam int SW    = INT_WIDTH + L2N;
  localparam int QW    = 2*INT_WIDTH + L2N;
  localparam int RSW   = INT_WIDTH + LD;
  localparam int RQW   = 2*INT_WIDTH + LD;
  localparam int DW    = QW + L2N + 1;
  localparam int MSH   = L2N - MEAN_FRAC;
  localparam int VSH   = 2*L2N - VAR_FRAC;
  localparam int EW    = 64;
  localparam logic signed [EW-1:0] SMAX = (64'sd1 <<< (STAT_W-1)) - 64'sd1;
  localparam logic signed [EW-1:0] SMIN = -(64'sd1 <<< (STAT_W-1));

  ln_state_e              state_q;
  logic [BW-1:0]          beat_cnt_q;
  logic [AW-1:0]          idx_q;
  logic signed [SW-1:0]   sum_q, sum_d;
  logic [QW-1:0]          sumsq_q, sumsq_d;
  ln_stat_t               stat_q;
  logic                   wen_q;

  logic signed [RSW-1:0]  beat_sum;
  logic [RQW-1:0]         beat_sq;

  ln_beat_reduce #(.DATA_DEPTH(DATA_DEPTH), .INT_WIDTH(INT_WIDTH)) u_reduce (
    .data_i  (input_data),
    .sum_o   (beat_sum),
    .sumsq_o (beat_sq)
  );

  assign sum_d   = sum_q + SW'(beat_sum);
  assign sumsq_d = sumsq_q + QW'(beat_sq);

  // Mean: arithmetic shift floors, then clamp into signed STAT_W.
  logic signed [SW-1:0] mean_sh;
  logic signed [EW-1:0] mean_ext;
  logic [STAT_W-1:0]    mean_d;
  assign mean_sh  = sum_q >>> MSH;
  assign mean_ext = EW'(mean_sh);
  always_comb begin
    mean_d = mean_ext[STAT_W-1:0];
    if (mean_ext > SMAX)      mean_d = SMAX[STAT_W-1:0];
    else if (mean_ext < SMIN) mean_d = SMIN[STAT_W-1:0];
  end

  // Variance: N*sumsq - sum^2 is N^2*var exactly and never negative,
  // so the whole datapath stays unsigned after the single multiply.
  logic signed [2*SW-1:0] sum_ext;
  logic [2*SW-1:0]        sq;
  logic [DW-1:0]          d, v_sh;
  logic [STAT_W-1:0]      var_d;
  assign sum_ext = (2*SW)'(sum_q);
  assign sq      = sum_ext * sum_ext;
  assign d       = {1'b0, sumsq_q, {L2N{1'b0}}} - {1'b0, sq};
  assign v_sh    = d >> VSH;
  assign var_d   = (|v_sh[DW-1:STAT_W]) ? {STAT_W{1'b1}} : v_sh[STAT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACC;
      beat_cnt_q <= '0;
      idx_q      <= '0;
      sum_q      <= '0;
      sumsq_q    <= '0;
      stat_q     <= '0;
      wen_q      <= 1'b0;
    end else if (seq_clr) begin
      state_q    <= ACC;
      beat_cnt_q <= '0;
      idx_q      <= '0;
      sum_q      <= '0;
      sumsq_q    <= '0;
      wen_q      <= 1'b0;
    end else begin
      case (state_q)
        ACC: if (valid_in) begin
          sum_q   <= sum_d;
          sumsq_q <= sumsq_d;
          if (beat_cnt_q == BW'(BEATS-1)) begin
            beat_cnt_q <= '0;
            state_q    <= CALC;
          end else begin
            beat_cnt_q <= beat_cnt_q + BW'(1);
          end
        end
        CALC: begin
          stat_q.mean_q <= mean_d;
          stat_q.var_q  <= var_d;
          wen_q         <= 1'b1;
          state_q       <= WRITE;
        end
        WRITE: begin
          wen_q   <= 1'b0;
          sum_q   <= '0;
          sumsq_q <= '0;
          idx_q   <= (idx_q == AW'(LUT_DEPTH-1)) ? '0 : idx_q + AW'(1);
          state_q <= ACC;
        end
        default: state_q <= ACC;
      endcase
    end
  end

  assign in_ready  = (state_q == ACC);
  // seq_clr must kill the write in the same cycle, so it gates the strobe directly.
  assign lut_wen   = wen_q & ~seq_clr;
  assign tok_done  = lut_wen;
  assign lut_addr  = idx_q;
  assign lut_wdata = stat_q;
endmodule

// File: tb/tb_ln_stat_collector.sv
module tb_ln_stat_collector;
  logic        clk = 1'b0;
  logic        rst_n, seq_clr, valid_in, in_ready, lut_wen, tok_done;
  logic [63:0] input_data;
  logic [7:0]  lut_addr;
  logic [31:0] lut_wdata;

  int checks = 0, errors = 0;
  int wr_cnt = 0, acc_cnt = 0, rdy_low = 0, done_bad = 0;
  logic [7:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  ln_stat_collector dut (
    .clk(clk), .rst_n(rst_n), .seq_clr(seq_clr), .valid_in(valid_in),
    .in_ready(in_ready), .input_data(input_data), .lut_wen(lut_wen),
    .lut_addr(lut_addr), .lut_wdata(lut_wdata), .tok_done(tok_done)
  );

  always #5 clk = ~clk;

  // Inputs change at posedge+1, so the negedge sees stable inputs and outputs.
  always @(negedge clk) begin
    if (lut_wen) begin
      wr_cnt++;
      wr_addr_q.push_back(lut_addr);
      wr_data_q.push_back(lut_wdata);
    end
    if (tok_done !== lut_wen) done_bad++;
    if (valid_in && in_ready && !seq_clr) acc_cnt++;
    if (!in_ready) rdy_low++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] mk_beat(input int mode, input int b, input logic [7:0] v);
    case (mode)
      0:       return {8{v}};
      1:       return 64'hFF01_FF01_FF01_FF01;
      default: return (b < 16) ? {8{8'h7F}} : {8{8'h80}};
    endcase
  endfunction

  task automatic send_beat(input logic [63:0] d);
    int n = 0;
    valid_in   = 1'b1;
    input_data = d;
    @(negedge clk);
    while (!in_ready && n < 8) begin
      step();
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_wait", {63'd0, in_ready}, 64'd1);
    step();
  endtask

  task automatic send_token(input int mode, input logic [7:0] v);
    for (int b = 0; b < 32; b++) send_beat(mk_beat(mode, b, v));
  endtask

  // Called right after the last beat is accepted: CALC cycle, then WRITE cycle.
  task automatic expect_write(input string tag, input logic [7:0] addr, input logic [31:0] data);
    valid_in = 1'b0;
    @(negedge clk);
    chk({tag, "_calc_wen"}, {63'd0, lut_wen}, 64'd0);
    step();
    @(negedge clk);
    chk({tag, "_wen"}, {63'd0, lut_wen}, 64'd1);
    chk({tag, "_done"}, {63'd0, tok_done}, 64'd1);
    chk({tag, "_addr"}, {56'd0, lut_addr}, {56'd0, addr});
    chk({tag, "_data"}, {32'd0, lut_wdata}, {32'd0, data});
    step();
  endtask

  initial begin
    int w0, a0, r0, q0;
    rst_n = 1'b0; seq_clr = 1'b0; valid_in = 1'b0; input_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_wen",   {63'd0, lut_wen},  64'd0);
    chk("rst_done",  {63'd0, tok_done}, 64'd0);
    chk("rst_addr",  {56'd0, lut_addr}, 64'd0);
    chk("rst_data",  {32'd0, lut_wdata}, 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Directed statistics
    send_token(0, 8'd3);   expect_write("t1_const3", 8'd0, 32'h0000_0300);
    send_token(1, 8'd0);   expect_write("t2_alt",    8'd1, 32'h0001_0000);
    send_token(0, 8'h80);  expect_write("t2_neg",    8'd2, 32'h0000_8000);
    send_token(2, 8'd0);   expect_write("t3_half",   8'd3, 32'h3F80_FF80);

    // 257 back-to-back tokens, valid held high
    seq_clr = 1'b1; step(); seq_clr = 1'b0;
    w0 = wr_cnt; a0 = acc_cnt; r0 = rdy_low; q0 = wr_addr_q.size();
    for (int t = 0; t < 257; t++) send_token(0, 8'(t % 8));
    valid_in = 1'b0;
    repeat (3) step();
    chk("t4_writes", 64'(wr_cnt - w0), 64'd257);
    chk("t4_beats",  64'(acc_cnt - a0), 64'd8224);
    chk("t4_rdylow", 64'(rdy_low - r0), 64'd514);
    for (int t = 0; t < 257; t++) begin
      if (q0 + t < wr_addr_q.size()) begin
        chk($sformatf("t4_addr%0d", t), {56'd0, wr_addr_q[q0+t]}, 64'(t % 256));
        chk($sformatf("t4_data%0d", t), {32'd0, wr_data_q[q0+t]}, 64'((t % 8) << 8));
      end
    end

    // Reset mid-token
    for (int b = 0; b < 10; b++) send_beat(mk_beat(0, b, 8'd5));
    valid_in = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_ready", {63'd0, in_ready}, 64'd1);
    chk("t5_rst_addr",  {56'd0, lut_addr}, 64'd0);
    chk("t5_rst_data",  {32'd0, lut_wdata}, 64'd0);
    step();
    rst_n = 1'b1;
    w0 = wr_cnt;
    send_token(0, 8'd3);   expect_write("t5_rst", 8'd0, 32'h0000_0300);
    repeat (2) step();
    chk("t5_rst_count", 64'(wr_cnt - w0), 64'd1);

    // seq_clr mid-token, with a beat presented alongside it
    send_token(0, 8'd1);   expect_write("t5_pre", 8'd1, 32'h0000_0100);
    for (int b = 0; b < 10; b++) send_beat(mk_beat(0, b, 8'd5));
    seq_clr = 1'b1; input_data = mk_beat(0, 0, 8'd7);
    step();
    seq_clr = 1'b0; valid_in = 1'b0;
    w0 = wr_cnt;
    send_token(0, 8'd3);   expect_write("t5_clr", 8'd0, 32'h0000_0300);
    repeat (2) step();
    chk("t5_clr_count", 64'(wr_cnt - w0), 64'd1);

    // seq_clr in the WRITE cycle of token 5
    seq_clr = 1'b1; step(); seq_clr = 1'b0;
    for (int t = 0; t < 5; t++) begin
      send_token(0, 8'd2);
      expect_write($sformatf("t6_tok%0d", t), 8'(t), 32'h0000_0200);
    end
    send_token(0, 8'd4);
    valid_in = 1'b0;
    @(negedge clk);
    chk("t6_calc_wen", {63'd0, lut_wen}, 64'd0);
    step();
    w0 = wr_cnt;
    seq_clr = 1'b1;
    @(negedge clk);
    chk("t6_supp_wen",  {63'd0, lut_wen},  64'd0);
    chk("t6_supp_done", {63'd0, tok_done}, 64'd0);
    step();
    seq_clr = 1'b0;
    repeat (2) step();
    chk("t6_no_write", 64'(wr_cnt - w0), 64'd0);
    send_token(0, 8'd6);   expect_write("t6_next", 8'd0, 32'h0000_0600);

    chk("tok_done_mirror", 64'(done_bad), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
